// File: rtl/apb_slave_regfile1.sv
// apb_slave_regfile1
// APB responder for one bit of a 16-bit select bus. It has a bank of 32-bit
// word registers: register 0 is a read-only ID and the others are read/write.
// The transfer is captured in the setup phase, and a programmable number of
// wait states is inserted before pready1. Bad accesses complete with pslverr1,
// and a saturating counter tracks how many errored transfers have completed.
module apb_slave_regfile1 #(
  parameter int          PADDR_WIDTH1  = 32,
  parameter int          PWDATA_WIDTH1 = 32,
  parameter int          PRDATA_WIDTH1 = 32,
  parameter int          NUM_REGS1     = 16,
  parameter int          SEL_INDEX1    = 0,
  parameter logic [31:0] ID_VALUE1     = 32'hA5B0_0001
) (
  input  logic                     pclock1,
  input  logic                     preset1,
  input  logic [PADDR_WIDTH1-1:0]  paddr1,
  input  logic                     prwd1,
  input  logic [PWDATA_WIDTH1-1:0] pwdata1,
  input  logic                     penable1,
  input  logic [15:0]              psel1,
  input  logic [3:0]               wait_cfg1,
  output logic                     pready1,
  output logic [PRDATA_WIDTH1-1:0] prdata1,
  output logic                     pslverr1,
  output logic [7:0]               err_count1
);

  localparam int IDX_W = $clog2(NUM_REGS1);
  localparam logic [PADDR_WIDTH1:0] ADDR_LIMIT = (PADDR_WIDTH1 + 1)'(4 * NUM_REGS1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [PADDR_WIDTH1-1:0]  addr_q, addr_d;
  logic                     write_q, write_d;
  logic [PWDATA_WIDTH1-1:0] wdata_q, wdata_d;
  logic [3:0]               wcnt_q, wcnt_d;
  logic                     pready_q, pready_d;
  logic                     pslverr_q, pslverr_d;
  logic [PRDATA_WIDTH1-1:0] prdata_q, prdata_d;
  logic [7:0]               err_count_q, err_count_d;
  logic [PRDATA_WIDTH1-1:0] regs_q [NUM_REGS1];
  logic [PRDATA_WIDTH1-1:0] regs_d [NUM_REGS1];

  logic                     sel;
  logic                     setup;
  logic                     completion;
  logic                     wr_en;
  logic [IDX_W-1:0]         setup_idx;
  logic [IDX_W-1:0]         q_idx;
  logic                     setup_err;
  logic                     q_err;
  logic [PRDATA_WIDTH1-1:0] setup_rdata;
  logic [PRDATA_WIDTH1-1:0] q_rdata;
  logic                     unused_sel_bits;

  // Error rule: outside the register window, unaligned, or a write to the ID register.
  function automatic logic access_err(input logic [PADDR_WIDTH1-1:0] a, input logic wr);
    logic out_of_range;
    logic misaligned;
    logic ro_write;
    out_of_range = ({1'b0, a} >= ADDR_LIMIT);
    misaligned   = (a[1:0] != 2'b00);
    ro_write     = wr && (a[IDX_W+1:2] == '0);
    return out_of_range || misaligned || ro_write;
  endfunction

  assign sel             = psel1[SEL_INDEX1];
  assign unused_sel_bits = ^psel1;

  // A setup phase is accepted in either state; in ACCESS it counts as a master restart.
  assign setup      = sel && !penable1;
  assign completion = (state_q == ST_ACCESS) && sel && penable1 && pready_q;
  assign wr_en      = completion && write_q && !pslverr_q;

  // Two decode paths are needed. The inputs are decoded for zero-wait
  // completions on the setup edge. The captured address is decoded when
  // wait states expire.
  assign setup_idx   = paddr1[IDX_W+1:2];
  assign q_idx       = addr_q[IDX_W+1:2];
  assign setup_err   = access_err(paddr1, prwd1);
  assign q_err       = access_err(addr_q, write_q);
  assign setup_rdata = (setup_idx == '0) ? PRDATA_WIDTH1'(ID_VALUE1) : regs_q[setup_idx];
  assign q_rdata     = (q_idx == '0) ? PRDATA_WIDTH1'(ID_VALUE1) : regs_q[q_idx];

  // State register and datapath flops.
  always_ff @(posedge pclock1 or posedge preset1) begin
    if (preset1) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wcnt_q      <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wcnt_q      <= wcnt_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic: enter ACCESS on setup, and return to IDLE on completion or when sel drops.
  always_comb begin
    state_d = state_q;
    if (setup) begin
      state_d = ST_ACCESS;
    end else if (state_q == ST_ACCESS) begin
      if (!sel || pready_q) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Transfer datapath: capture the transfer, count wait states, and present the response.
  always_comb begin
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wcnt_d      = wcnt_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    prdata_d    = prdata_q;
    err_count_d = err_count_q;
    if (setup) begin
      addr_d    = paddr1;
      write_d   = prwd1;
      wdata_d   = pwdata1;
      wcnt_d    = wait_cfg1;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      if (wait_cfg1 == 4'd0) begin
        pready_d  = 1'b1;
        pslverr_d = setup_err;
        prdata_d  = (!prwd1 && !setup_err) ? setup_rdata : '0;
      end
    end else if (state_q == ST_ACCESS) begin
      if (!sel) begin
        // Aborted transfer: there is no response, no write, and no error count.
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end else if (pready_q) begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (pslverr_q && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
      end else begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) begin
          pready_d  = 1'b1;
          pslverr_d = q_err;
          prdata_d  = (!write_q && !q_err) ? q_rdata : '0;
        end
      end
    end
  end

  // Register bank update: only a clean write completion changes a register, and entry 0 stays unused.
  always_comb begin
    for (int i = 0; i < NUM_REGS1; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[q_idx] = wdata_q;
    end
    regs_d[0] = '0;
  end

  // Register bank storage.
  always_ff @(posedge pclock1 or posedge preset1) begin
    if (preset1) begin
      for (int i = 0; i < NUM_REGS1; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS1; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Output assignments.
  always_comb begin
    pready1    = pready_q;
    pslverr1   = pslverr_q;
    prdata1    = prdata_q;
    err_count1 = err_count_q;
  end

endmodule

// File: tb/tb_apb_slave_regfile1.sv
// Directed testbench for apb_slave_regfile1. Each scenario task drives its
// own stimulus and checks the results against hand-computed values.
module tb_apb_slave_regfile1;

  logic        pclock1;
  logic        preset1;
  logic [31:0] paddr1;
  logic        prwd1;
  logic [31:0] pwdata1;
  logic        penable1;
  logic [15:0] psel1;
  logic [3:0]  wait_cfg1;
  logic        pready1;
  logic [31:0] prdata1;
  logic        pslverr1;
  logic [7:0]  err_count1;

  int checks;
  int failures;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  apb_slave_regfile1 dut (
    .pclock1   (pclock1),
    .preset1   (preset1),
    .paddr1    (paddr1),
    .prwd1     (prwd1),
    .pwdata1   (pwdata1),
    .penable1  (penable1),
    .psel1     (psel1),
    .wait_cfg1 (wait_cfg1),
    .pready1   (pready1),
    .prdata1   (prdata1),
    .pslverr1  (pslverr1),
    .err_count1(err_count1)
  );

  initial pclock1 = 1'b0;
  always #5 pclock1 = ~pclock1;

  // Driver: call this at #1 after a rising edge, and the current cycle becomes
  // the setup cycle. The task returns at #1 after the completion edge, with
  // the bus released. waits is the number of access cycles in which pready1
  // was low, or -1 if pready1 never came.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd, output logic err,
                      output int waits);
    bit got;
    got   = 0;
    rd    = '0;
    err   = 1'b0;
    waits = -1;
    psel1     = 16'h0001;
    penable1  = 1'b0;
    paddr1    = a;
    prwd1     = wr;
    pwdata1   = wd;
    wait_cfg1 = ws;
    @(posedge pclock1); #1;
    penable1  = 1'b1;
    wait_cfg1 = 4'hF;                 // changing wait_cfg1 in flight must not matter
    for (int i = 0; i < 24; i++) begin
      @(negedge pclock1);
      if (pready1 === 1'b1) begin
        rd    = prdata1;
        err   = pslverr1;
        waits = i;
        got   = 1;
        break;
      end
      @(posedge pclock1); #1;
    end
    if (got) begin
      @(posedge pclock1); #1;
    end
    psel1    = 16'h0000;
    penable1 = 1'b0;
    wait_cfg1 = 4'd0;
  endtask

  task automatic test_reset();
    preset1 = 1'b1;
    psel1 = '0; penable1 = 0; paddr1 = '0; prwd1 = 0; pwdata1 = '0; wait_cfg1 = '0;
    repeat (3) @(posedge pclock1);
    @(negedge pclock1);
    checks++; if (pready1 !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", pready1); end
    checks++; if (prdata1 !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", prdata1); end
    checks++; if (pslverr1 !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", pslverr1); end
    checks++; if (err_count1 !== 8'h0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", err_count1); end
    preset1 = 1'b0;
    @(posedge pclock1); #1;
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int w;
    xfer(32'h04, 1, 32'h1234_5678, 4'd0, rd, err, w);
    $display("write a=04 d=12345678 waits=%0d err=%b", w, err);
    checks++; if (w !== 0) begin failures++; $display("FAIL wr04_waits got=%0d exp=0", w); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr04_err got=%b exp=0", err); end
    @(negedge pclock1);
    checks++; if (pready1 !== 1'b0 || prdata1 !== 32'h0) begin failures++; $display("FAIL post_compl_clear pready=%b prdata=%h exp=0/0", pready1, prdata1); end
    @(posedge pclock1); #1;
    xfer(32'h04, 0, 32'h0, 4'd0, rd, err, w);
    $display("read a=04 d=%h waits=%0d err=%b", rd, w, err);
    checks++; if (w !== 0) begin failures++; $display("FAIL rd04_waits got=%0d exp=0", w); end
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL rd04_data got=%h exp=12345678", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rd04_err got=%b exp=0", err); end
    // back-to-back write then read of another register, no idle cycle between
    xfer(32'h14, 1, 32'hCAFE_0014, 4'd1, rd, err, w);
    $display("write a=14 d=cafe0014 waits=%0d err=%b", w, err);
    checks++; if (w !== 1 || err !== 1'b0) begin failures++; $display("FAIL wr14 waits=%0d err=%b exp=1/0", w, err); end
    xfer(32'h14, 0, 32'h0, 4'd2, rd, err, w);
    $display("read a=14 d=%h waits=%0d err=%b", rd, w, err);
    checks++; if (w !== 2 || rd !== 32'hCAFE_0014) begin failures++; $display("FAIL b2b_rd14 waits=%0d data=%h exp=2/cafe0014", w, rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int w;
    xfer(32'h00, 0, 32'h0, 4'd3, rd, err, w);
    $display("read a=00 d=%h waits=%0d err=%b", rd, w, err);
    checks++; if (w !== 3) begin failures++; $display("FAIL ws3_waits got=%0d exp=3", w); end
    checks++; if (rd !== ID) begin failures++; $display("FAIL ws3_id got=%h exp=%h", rd, ID); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int w;
    logic [31:0] addrs [3];
    addrs[0] = 32'h00; addrs[1] = 32'h40; addrs[2] = 32'h06;
    for (int i = 0; i < 3; i++) begin
      xfer(addrs[i], 1, 32'hFFFF_FFFF, 4'd0, rd, err, w);
      $display("write a=%h d=ffffffff waits=%0d err=%b", addrs[i], w, err);
      checks++; if (err !== 1'b1 || w !== 0) begin failures++; $display("FAIL err_wr_%h err=%b waits=%0d exp=1/0", addrs[i], err, w); end
    end
    checks++; if (err_count1 !== 8'd3) begin failures++; $display("FAIL errcnt3 got=%0d exp=3", err_count1); end
    xfer(32'h00, 0, 32'h0, 4'd0, rd, err, w);
    $display("read a=00 d=%h err=%b", rd, err);
    checks++; if (rd !== ID || err !== 1'b0) begin failures++; $display("FAIL id_after_err d=%h err=%b exp=%h/0", rd, err, ID); end
    xfer(32'h44, 0, 32'h0, 4'd2, rd, err, w);
    $display("read a=44 d=%h waits=%0d err=%b", rd, w, err);
    checks++; if (rd !== 32'h0 || err !== 1'b1 || w !== 2) begin failures++; $display("FAIL err_rd44 d=%h err=%b waits=%0d exp=0/1/2", rd, err, w); end
    checks++; if (err_count1 !== 8'd4) begin failures++; $display("FAIL errcnt4 got=%0d exp=4", err_count1); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int w; bit seen;
    seen = 0;
    psel1 = 16'h0001; penable1 = 0; paddr1 = 32'h0C; prwd1 = 1; pwdata1 = 32'h5555_AAAA; wait_cfg1 = 4'd2;
    @(posedge pclock1); #1; penable1 = 1;
    @(negedge pclock1); if (pready1 !== 1'b0) seen = 1;
    @(posedge pclock1); #1; psel1 = 16'h0000; penable1 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclock1); if (pready1 !== 1'b0 || pslverr1 !== 1'b0) seen = 1;
    end
    $display("abort write a=0c spurious_response=%0d", seen);
    checks++; if (seen) begin failures++; $display("FAIL abort_no_ready got=1 exp=0"); end
    @(posedge pclock1); #1;
    xfer(32'h0C, 0, 32'h0, 4'd0, rd, err, w);
    $display("read a=0c d=%h waits=%0d err=%b", rd, w, err);
    checks++; if (rd !== 32'h0 || err !== 1'b0 || w !== 0) begin failures++; $display("FAIL abort_reg_unchanged d=%h err=%b waits=%0d exp=0/0/0", rd, err, w); end
    checks++; if (err_count1 !== 8'd4) begin failures++; $display("FAIL abort_errcnt got=%0d exp=4", err_count1); end
  endtask

  task automatic test_restart();
    logic [31:0] rd; logic err; int w;
    psel1 = 16'h0001; penable1 = 0; paddr1 = 32'h10; prwd1 = 1; pwdata1 = 32'hDEAD_BEEF; wait_cfg1 = 4'd2;
    @(posedge pclock1); #1; penable1 = 1;
    @(posedge pclock1); #1;
    penable1 = 0; paddr1 = 32'h04; prwd1 = 0; wait_cfg1 = 4'd0;   // master restart as read of 0x04
    @(posedge pclock1); #1; penable1 = 1;
    @(negedge pclock1);
    $display("restart read a=04 pready=%b d=%h err=%b", pready1, prdata1, pslverr1);
    checks++; if (pready1 !== 1'b1 || prdata1 !== 32'h1234_5678 || pslverr1 !== 1'b0) begin
      failures++; $display("FAIL restart_read pready=%b d=%h err=%b exp=1/12345678/0", pready1, prdata1, pslverr1);
    end
    @(posedge pclock1); #1; psel1 = 0; penable1 = 0;
    xfer(32'h10, 0, 32'h0, 4'd0, rd, err, w);
    $display("read a=10 d=%h err=%b", rd, err);
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL restart_discard d=%h err=%b exp=0/0", rd, err); end
  endtask

  task automatic test_ignored();
    bit seen;
    seen = 0;
    psel1 = 16'h0001; penable1 = 1; paddr1 = 32'h04; prwd1 = 0;   // access phase without setup
    for (int i = 0; i < 4; i++) begin
      @(negedge pclock1); if (pready1 !== 1'b0) seen = 1;
    end
    $display("penable without setup response=%0d", seen);
    checks++; if (seen) begin failures++; $display("FAIL idle_penable got=1 exp=0"); end
    seen = 0;
    @(posedge pclock1); #1;
    psel1 = 16'h0002; penable1 = 0; paddr1 = 32'h04; prwd1 = 1; pwdata1 = 32'h0; wait_cfg1 = 0;
    @(posedge pclock1); #1; penable1 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclock1); if (pready1 !== 1'b0) seen = 1;
    end
    $display("psel1[1] transfer response=%0d", seen);
    checks++; if (seen) begin failures++; $display("FAIL other_sel got=1 exp=0"); end
    @(posedge pclock1); #1; psel1 = 0; penable1 = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int w;
    psel1 = 16'h0001; penable1 = 0; paddr1 = 32'h08; prwd1 = 1; pwdata1 = 32'h0BAD_F00D; wait_cfg1 = 4'd0;
    @(posedge pclock1); #1; penable1 = 1;
    checks++; if (pready1 !== 1'b1) begin failures++; $display("FAIL pre_reset_pready got=%b exp=1", pready1); end
    #1 preset1 = 1'b1;
    #1;
    $display("reset mid-access pready=%b d=%h err=%b errcnt=%0d", pready1, prdata1, pslverr1, err_count1);
    checks++; if (pready1 !== 1'b0 || prdata1 !== 32'h0 || pslverr1 !== 1'b0 || err_count1 !== 8'd0) begin
      failures++; $display("FAIL async_reset pready=%b d=%h err=%b cnt=%0d exp=0/0/0/0", pready1, prdata1, pslverr1, err_count1);
    end
    psel1 = 0; penable1 = 0;
    @(posedge pclock1); #1; preset1 = 1'b0;
    @(posedge pclock1); #1;
    xfer(32'h08, 0, 32'h0, 4'd0, rd, err, w);
    $display("read a=08 d=%h err=%b", rd, err);
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL lost_write08 d=%h err=%b exp=0/0", rd, err); end
    xfer(32'h04, 0, 32'h0, 4'd0, rd, err, w);
    $display("read a=04 d=%h err=%b", rd, err);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reg04_cleared d=%h exp=0", rd); end
  endtask

  task automatic test_saturation();
    logic [31:0] rd; logic err; int w; int bad;
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      xfer(32'h00, 1, 32'h1, 4'd0, rd, err, w);
      if (err !== 1'b1 || w !== 0) bad++;
      if (i == 254) begin
        checks++; if (err_count1 !== 8'd255) begin failures++; $display("FAIL errcnt_255 got=%0d exp=255", err_count1); end
      end
    end
    $display("260 errored writes errcnt=%0d bad_responses=%0d", err_count1, bad);
    checks++; if (bad != 0) begin failures++; $display("FAIL sat_responses bad=%0d exp=0", bad); end
    checks++; if (err_count1 !== 8'd255) begin failures++; $display("FAIL errcnt_sat got=%0d exp=255", err_count1); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_errors();
    test_abort();
    test_restart();
    test_ignored();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile1.md
# apb_slave_regfile1

APB responder that terminates one select line of the APB master interface's 16-bit `psel1` bus and exposes a bank of 32-bit registers. Decodes setup/access phases, inserts a configurable number of wait states and returns `prdata1` and `pslverr1` with `pready1`. Sits on the APB fabric as the slave-side counterpart used by both the DUT subsystem and the APB UVC bench as a reference responder.

## Interface
- `PADDR_WIDTH1`, 32, address width; must be ≥ clog2(`NUM_REGS1`)+2
- `PWDATA_WIDTH1`, 32, write data width; must equal `PRDATA_WIDTH1`
- `PRDATA_WIDTH1`, 32, read data width
- `NUM_REGS1`, 16, number of word registers (2..256)
- `SEL_INDEX1`, 0, which `psel1` bit selects this slave (0..15)
- `ID_VALUE1`, 32'hA5B0_0001, read-only contents of register 0
- `pclock1`  in  1  APB clock; all state on rising edge
- `preset1`  in  1  reset, asynchronous, active-high
- `paddr1`  in  PADDR_WIDTH1  byte address
- `prwd1`  in  1  1 = write, 0 = read
- `pwdata1`  in  PWDATA_WIDTH1  write data
- `penable1`  in  1  access phase indicator
- `psel1`  in  16  one-hot slave selects; only bit `SEL_INDEX1` used
- `wait_cfg1`  in  4  wait states to insert, sampled in setup phase
- `pready1`  out  1  transfer completion
- `prdata1`  out  PRDATA_WIDTH1  read data
- `pslverr1`  out  1  transfer error, valid only with `pready1`
- `err_count1`  out  8  saturating count of completed errored transfers

## Operation
- `sel` = `psel1[SEL_INDEX1]`. States: IDLE, ACCESS.
- IDLE: on edge with `sel && !penable1` (setup): capture `paddr1`, `prwd1`, `pwdata1`; load `wcnt` = `wait_cfg1`; go ACCESS. If `wait_cfg1`==0, assert `pready1` on this edge.
- ACCESS, `sel && penable1`, `pready1`==0: decrement `wcnt`; when `wcnt`==1, assert `pready1` on this edge.
- ACCESS, `sel && penable1 && pready1` (completion edge): commit write if no error; drop `pready1`, `pslverr1`, `prdata1` to 0; go IDLE.
- Registers: index = `paddr1[clog2(NUM_REGS1)+1:2]`. Error if `paddr1` ≥ 4·`NUM_REGS1`, `paddr1[1:0]`≠0, or write to index 0. Error → `pslverr1`=1 with `pready1`, no register change, read data 0.
- Reads: `prdata1` loaded with register (index 0 → `ID_VALUE1`) on the edge `pready1` rises; 0 at all other times.
- `err_count1` increments on each errored completion edge; saturates at 255.
- Write visibility: a read whose setup follows a write's completion edge returns the new value.

## Timing
- Reset (async, while `preset1`=1): state IDLE, `pready1`=0, `prdata1`=0, `pslverr1`=0, `err_count1`=0, all registers 0 (register 0 reads `ID_VALUE1`).
- Latency: setup cycle T0, access T1; `pready1` high in cycle T1+`wait_cfg1`. Zero wait → single access cycle.
- `pready1` high exactly one cycle per transfer; `pslverr1` never high without `pready1`.
- Back-to-back: new setup on the cycle after completion accepted normally.
- `sel` low while in ACCESS: abort, IDLE, no write, outputs 0 next edge, no error count.
- `sel && !penable1` while in ACCESS (master restart): discard old transfer, treat as new setup.
- `penable1` high in IDLE without prior setup: ignored, no response.
- `wait_cfg1` changes after setup: no effect on transfer in flight.
- Reset asserted mid-transfer: outputs clear immediately; pending write lost.

## Test plan
- Write 0x1234_5678 to addr 0x04, wait 0, then read 0x04 -> `pready1` high in first access cycle both times; read `prdata1`=0x1234_5678, `pslverr1`=0.
- Read addr 0x00 with `wait_cfg1`=3 -> `pready1` low 3 access cycles, high on 4th; `prdata1`=0xA5B0_0001.
- Write 0xFFFF_FFFF to 0x00, then to 0x40 (NUM_REGS1=16), then to 0x06 -> each completes with `pslverr1`=1, reg 0 still reads ID, `err_count1`=3.
- Drop `psel1[0]` after 1 access cycle of a write with `wait_cfg1`=2 -> no `pready1`, register unchanged, next transfer completes normally.
- Assert `preset1` during access of write to 0x08 -> outputs 0 within same cycle, reg 0x08 reads 0 after reset.
- 260 errored transfers -> `err_count1` stops at 255; `psel1[1]`-only traffic -> no response.
